// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: default widths, the
// serializer state encoding and a helper for the bytes-per-word count.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 32;
  localparam int unsigned BYTE_W      = 8;

  // IDLE: no word held; LOAD: waiting on the registered FIFO read port;
  // SEND: shifting bytes out on the valid/ready stream.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } state_e;

  // Number of output symbols per FIFO word. data_w must be a multiple of byte_w.
  function automatic int unsigned nbytes(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_byte_sel_mux.sv
// Combinational byte lane selector: picks the symbol of a word addressed by
// byte_idx, with index 0 mapping to either the top or the bottom lane.
module byte_sel_mux #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned IDX_W     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic [DATA_W-1:0] word,
  input  logic [IDX_W-1:0]  byte_idx,
  output logic [BYTE_W-1:0] sel_byte
);

  localparam int unsigned NBYTES = DATA_W / BYTE_W;

  // Physical lane number: lane 0 is bits [BYTE_W-1:0].
  logic [IDX_W-1:0] lane;

  // Translate the transmit order index into a lane and multiplex it out.
  always_comb begin
    if (MSB_FIRST) begin
      lane = IDX_W'(NBYTES - 1) - byte_idx;
    end else begin
      lane = byte_idx;
    end
    sel_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane == IDX_W'(i)) begin
        sel_byte = word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// Drain stage for the synchronous word FIFO: pops one word at a time and
// streams it out as bytes on a valid/ready interface, counting finished words.
// The FIFO read port is registered, so every pop is followed by a one-cycle
// LOAD state before the word can be captured.
module fifo_word_serializer #(
  parameter int unsigned DATA_W    = fifo_pkg::FIFO_DATA_W,
  parameter int unsigned BYTE_W    = fifo_pkg::BYTE_W,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  import fifo_pkg::*;

  localparam int unsigned NBYTES = nbytes(DATA_W, BYTE_W);
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]  word_q;
  logic [CNT_W-1:0]   words_sent_q;

  logic last_hs;
  logic pop;

  // Handshake and pop decode. A pop on the final handshake lets the next word
  // load immediately, so back-to-back words cost only the single LOAD bubble.
  // The rst term keeps the pop request low during the reset cycle itself.
  always_comb begin
    last_hs = (state_q == ST_SEND) && m_ready && (byte_idx_q == LAST_IDX);
    pop     = !rst && !fifo_empty && ((state_q == ST_IDLE) || last_hs);
  end

  // Next-state and byte index logic.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // fifo_rd_data is valid now; it is captured on this edge.
        state_d    = ST_SEND;
        byte_idx_d = '0;
      end
      ST_SEND: begin
        if (m_ready) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d    = pop ? ST_LOAD : ST_IDLE;
            byte_idx_d = '0;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        byte_idx_d = '0;
      end
    endcase
  end

  // State, held word and completed-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      word_q       <= '0;
      words_sent_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      if (state_q == ST_LOAD) begin
        word_q <= fifo_rd_data;
      end
      // Counter wraps naturally from all-ones to zero.
      if (last_hs) begin
        words_sent_q <= words_sent_q + CNT_W'(1);
      end
    end
  end

  // Byte lane selection; word_q only changes in LOAD so m_data is stable
  // while a byte waits for m_ready.
  byte_sel_mux #(
    .DATA_W   (DATA_W),
    .BYTE_W   (BYTE_W),
    .IDX_W    (IDX_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_byte_sel (
    .word    (word_q),
    .byte_idx(byte_idx_q),
    .sel_byte(m_data)
  );

  // Registered-state outputs.
  always_comb begin
    fifo_rd_en = pop;
    m_valid    = (state_q == ST_SEND);
    m_last     = (state_q == ST_SEND) && (byte_idx_q == LAST_IDX);
    busy       = (state_q != ST_IDLE);
    words_sent = words_sent_q;
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: a queue-based FIFO model feeds two DUTs
// (MSB-first with a 16-bit counter, LSB-first with a 4-bit counter for wrap),
// and a scoreboard checks every accepted byte in order.
module tb_fifo_word_serializer;

  logic clk = 1'b0;
  logic rst;
  logic m_ready;

  // MSB-first instance
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        m_valid, m_last, busy;
  logic [7:0]  m_data;
  logic [15:0] words_sent;

  // LSB-first instance
  logic        fifo_empty_l = 1'b1;
  logic        fifo_rd_en_l;
  logic [31:0] fifo_rd_data_l = '0;
  logic        m_valid_l, m_last_l, busy_l;
  logic [7:0]  m_data_l;
  logic [3:0]  words_sent_l;

  logic [31:0] fq[$];
  logic [31:0] fq_l[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_l[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int vcnt    = 0;
  int ld_cnt  = 0;
  int hs_cyc  = 0;

  always #5 clk = ~clk;

  fifo_word_serializer #(
    .DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .words_sent(words_sent)
  );

  fifo_word_serializer #(
    .DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b0), .CNT_W(4)
  ) dut_lsb (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_l), .fifo_rd_en(fifo_rd_en_l),
    .fifo_rd_data(fifo_rd_data_l), .m_valid(m_valid_l), .m_ready(m_ready),
    .m_data(m_data_l), .m_last(m_last_l), .busy(busy_l), .words_sent(words_sent_l)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO models with a registered read port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
    if (fifo_rd_en_l && fq_l.size() > 0) fifo_rd_data_l <= fq_l.pop_front();
    fifo_empty_l <= (fq_l.size() == 0);
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) begin
        rd_cnt++;
        check("rd_en_while_empty", {63'd0, fifo_empty}, 64'd0);
        if (m_valid) check("pop_on_last", {62'd0, m_last, m_ready}, 64'd3);
      end
      if (m_valid) vcnt++;
      if (busy && !m_valid) ld_cnt++;
      if (m_valid && m_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) check("extra_byte", {1'b1, m_last, m_data}, 64'd0);
        else check("byte", {m_last, m_data}, exp_q.pop_front());
      end
      if (fifo_rd_en_l) check("rd_en_while_empty_l", {63'd0, fifo_empty_l}, 64'd0);
      if (m_valid_l && m_ready) begin
        if (exp_l.size() == 0) check("extra_byte_l", {1'b1, m_last_l, m_data_l}, 64'd0);
        else check("byte_l", {m_last_l, m_data_l}, exp_l.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msb(input logic [31:0] w);
    fq.push_back(w);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), w[31-8*k -: 8]});
  endtask

  task automatic push_lsb(input logic [31:0] w);
    fq_l.push_back(w);
    for (int k = 0; k < 4; k++) exp_l.push_back({(k == 3), w[8*k +: 8]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.delete();
    fq_l.delete();
    exp_q.delete();
    exp_l.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the first pop; returns its cycle number.
  task automatic wait_pop(output int t0);
    logic seen;
    seen = 1'b0;
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        seen = 1'b1;
        t0 = cyc;
        break;
      end
    end
    check("pop_seen", {63'd0, seen}, 64'd1);
    tick();
  endtask

  // Waits (bounded) until the MSB DUT presents the given byte.
  task automatic wait_byte(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid && m_data == b) begin
        seen = 1'b1;
        break;
      end
    end
    check("byte_seen", {63'd0, seen}, 64'd1);
  endtask

  int t0, b_rd, b_v, b_ld;

  initial begin
    rst = 1'b1;
    m_ready = 1'b1;
    // Word already queued while reset is held: pop must stay masked.
    push_msb(32'hCAFEF00D);
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_valid", {63'd0, m_valid}, 64'd0);
    check("rst_last", {63'd0, m_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_words", {48'd0, words_sent}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) tick();
    check("post_rst_words", {48'd0, words_sent}, 64'd1);

    // Empty FIFO for 50 cycles.
    do_reset();
    b_rd = rd_cnt; b_v = vcnt;
    repeat (50) tick();
    check("empty_pops", 64'(rd_cnt - b_rd), 64'd0);
    check("empty_valid", 64'(vcnt - b_v), 64'd0);
    check("empty_words", {48'd0, words_sent}, 64'd0);

    // Single word, MSB first.
    b_rd = rd_cnt; b_ld = ld_cnt;
    push_msb(32'hA1B2C3D4);
    wait_pop(t0);
    repeat (8) tick();
    check("single_words", {48'd0, words_sent}, 64'd1);
    check("single_busy", {63'd0, busy}, 64'd0);
    check("single_pops", 64'(rd_cnt - b_rd), 64'd1);
    check("single_load", 64'(ld_cnt - b_ld), 64'd1);
    check("single_latency", 64'(hs_cyc - t0), 64'd5);
    check("single_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back words.
    do_reset();
    b_rd = rd_cnt; b_ld = ld_cnt;
    push_msb(32'h01020304);
    push_msb(32'h05060708);
    wait_pop(t0);
    repeat (14) tick();
    check("b2b_words", {48'd0, words_sent}, 64'd2);
    check("b2b_pops", 64'(rd_cnt - b_rd), 64'd2);
    check("b2b_load", 64'(ld_cnt - b_ld), 64'd2);
    check("b2b_span", 64'(hs_cyc - t0), 64'd10);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure on B2 for three cycles.
    b_rd = rd_cnt;
    push_msb(32'hA1B2C3D4);
    wait_byte(8'hA1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_data", {56'd0, m_data}, 64'h00B2);
      check("bp_valid", {63'd0, m_valid}, 64'd1);
      check("bp_last", {63'd0, m_last}, 64'd0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    repeat (8) tick();
    check("bp_words", {48'd0, words_sent}, 64'd3);
    check("bp_pops", 64'(rd_cnt - b_rd), 64'd1);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset after B2 is accepted.
    push_msb(32'hA1B2C3D4);
    wait_byte(8'hB2);
    @(posedge clk); #1;
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_valid", {63'd0, m_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_words", {48'd0, words_sent}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_msb(32'h11223344);
    repeat (10) tick();
    check("midrst_restart_words", {48'd0, words_sent}, 64'd1);
    check("midrst_drained", 64'(exp_q.size()), 64'd0);

    // LSB-first ordering and counter wrap on the 4-bit instance.
    push_lsb(32'hA1B2C3D4);
    for (int i = 1; i < 15; i++) push_lsb(32'h01010101 * i + 32'h00102030);
    repeat (90) tick();
    check("lsb_words_15", {60'd0, words_sent_l}, 64'd15);
    check("lsb_drained", 64'(exp_l.size()), 64'd0);
    push_lsb(32'hDEADBEEF);
    repeat (10) tick();
    check("lsb_wrap", {60'd0, words_sent_l}, 64'd0);
    check("lsb_wrap_drained", 64'(exp_l.size()), 64'd0);
    check("lsb_busy", {63'd0, busy_l}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
